instruction_loader: RTL

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader_pkg.sv | 24 ++
 rtl/instruction_loader_byte_assembler.sv | 40 ++++
 rtl/instruction_loader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared constants and FSM encoding for the serial instruction loader and
// the instruction-memory halt check.
package instruction_loader_pkg;

  // Opcode field value in bits [31:26] that marks the final program word.
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  // Received bytes per instruction word.
  localparam int BYTES_PER_WORD = 4;

  // Loader state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  // True when a word carries the HALT opcode in its top six bits.
  function automatic logic is_halt(input logic [31:0] word);
    return (word[31:26] == HALT_OPCODE);
  endfunction

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Big-endian byte-to-word shift buffer with a wrapping byte index.
// o_word is the word as it will look after the current shift, so the
// owner can capture it on the same edge that completes it.
module byte_assembler
  import instruction_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_clear,
  input  logic                  i_shift,
  input  logic [7:0]            i_byte,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_valid
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [DATA_WIDTH-1:0] r_buf;
  logic [1:0]            r_idx;

  // Shift the new byte in at the low end; earlier bytes move toward the MSBs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_buf <= '0;
      r_idx <= 2'd0;
    end else if (i_clear) begin
      r_buf <= '0;
      r_idx <= 2'd0;
    end else if (i_shift) begin
      r_buf <= {r_buf[DATA_WIDTH-9:0], i_byte};
      r_idx <= r_idx + 2'd1;
    end
  end

  assign o_word       = {r_buf[DATA_WIDTH-9:0], i_byte};
  assign o_word_valid = i_shift && (r_idx == LAST_IDX);

endmodule

// File: rtl/instruction_loader.sv
// Serial program loader: assembles received bytes into 32-bit instruction
// words and writes them to instruction memory until a HALT word is written
// or the memory is full.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  loader_state_t         r_state;
  loader_state_t         w_next;
  logic                  w_shift;
  logic                  w_clear;
  logic                  w_halt;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_word_valid;
  logic [ADDR_WIDTH:0]   w_count_inc;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic                  r_error;

  byte_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_byte_assembler (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clear      (w_clear),
    .i_shift      (w_shift),
    .i_byte       (i_rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  assign w_count_inc = r_word_count + 1'b1;
  assign w_halt      = is_halt(r_wr_data);
  // A non-HALT word that fills the last slot ends the load as an overflow.
  assign w_full      = (w_count_inc == LP_DEPTH);

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic plus byte-accept and clear strobes for the assembler.
  always_comb begin
    w_next  = r_state;
    w_shift = 1'b0;
    w_clear = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_next  = ST_RECV;
          w_clear = 1'b1;
        end
      end
      ST_RECV: begin
        w_shift = i_rx_valid;
        if (w_word_valid) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (w_halt || w_full) begin
          w_next = ST_DONE;
        end else begin
          // A byte arriving during the write cycle starts the next word.
          w_next  = ST_RECV;
          w_shift = i_rx_valid;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Address, word counter, error flag and the captured write word.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_word_count <= '0;
      r_error      <= 1'b0;
    end else begin
      if (w_clear) begin
        r_addr       <= '0;
        r_word_count <= '0;
        r_error      <= 1'b0;
      end
      if (r_state == ST_RECV && w_word_valid) begin
        r_wr_data <= w_word;
      end
      if (r_state == ST_WRITE) begin
        r_addr       <= r_addr + 1'b1;
        r_word_count <= w_count_inc;
        r_error      <= !w_halt && w_full;
      end
    end
  end

  assign o_wr_en      = (r_state == ST_WRITE);
  assign o_wr_addr    = r_addr;
  assign o_wr_data    = r_wr_data;
  assign o_busy       = (r_state == ST_RECV) || (r_state == ST_WRITE);
  assign o_done       = (r_state == ST_DONE);
  assign o_error      = r_error;
  assign o_word_count = r_word_count;

endmodule
